// File: rtl/posit_dot_seq.sv
// Dot-product sequencer in front of a posit MAC: purges the quire, streams operand pairs
// as registered MAC enables, requests the result and holds it on a valid/ready port.
module posit_dot_seq #(
  parameter int unsigned N     = 8,
  parameter int unsigned LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic [N-1:0]     mac_in1,
  output logic [N-1:0]     mac_in2,
  output logic             mac_en,
  output logic             mac_purge,
  output logic             mac_req,
  input  logic [N-1:0]     mac_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_data,
  output logic             busy
);

  typedef enum logic [2:0] {StIdle, StClr, StAcc, StFlush, StReq, StDone} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] cnt_q;
  logic             accept;

  assign accept = in_valid & in_ready;

  // All outputs are registered; each is set on entry to the state that owns it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      in_ready  <= 1'b0;
      mac_in1   <= '0;
      mac_in2   <= '0;
      mac_en    <= 1'b0;
      mac_purge <= 1'b0;
      mac_req   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      busy      <= 1'b0;
    end else begin
      mac_purge <= 1'b0;
      mac_req   <= 1'b0;
      mac_en    <= accept;
      if (accept) begin
        mac_in1 <= in_a;
        mac_in2 <= in_b;
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q     <= len;
            state_q   <= StClr;
            mac_purge <= 1'b1;
            busy      <= 1'b1;
          end
        end
        StClr: begin
          if (cnt_q != '0) begin
            state_q  <= StAcc;
            in_ready <= 1'b1;
          end else begin
            state_q <= StReq;
            mac_req <= 1'b1;
          end
        end
        StAcc: begin
          if (accept) begin
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_q  <= StFlush;
              in_ready <= 1'b0;
            end
          end
        end
        StFlush: begin
          // Last product is absorbed by the quire at the end of this cycle.
          state_q <= StReq;
          mac_req <= 1'b1;
        end
        StReq: begin
          res_data  <= mac_out;
          res_valid <= 1'b1;
          state_q   <= StDone;
        end
        StDone: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_dot_seq.sv
// Bench for posit_dot_seq with a behavioural posit8 (es=0) quire MAC and a result scoreboard.
module tb_posit_dot_seq;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       start = 1'b0;
  logic [7:0] len = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [7:0] mac_in1, mac_in2;
  logic       mac_en, mac_purge, mac_req;
  logic [7:0] mac_out;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_data;
  logic       busy;

  posit_dot_seq #(.N(8), .LEN_W(8)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mac_in1   (mac_in1),
    .mac_in2   (mac_in2),
    .mac_en    (mac_en),
    .mac_purge (mac_purge),
    .mac_req   (mac_req),
    .mac_out   (mac_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  int         n_vec = 0;
  int         n_bad = 0;
  int         n_purge, n_en, n_req, n_ovl;
  int         cyc_rel, req_cyc;
  logic [7:0] sb[$];
  logic [7:0] a_tab[4];
  logic [7:0] b_tab[4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // posit8, es=0 -> signed fixed point with 24 fractional bits (NaR not exercised)
  function automatic longint p2q(input logic [7:0] p);
    logic [7:0] a;
    int         k, i, fb;
    logic       r;
    longint     m, v;
    if (p == 8'h00 || p == 8'h80) return 0;
    a = p[7] ? 8'(-p) : p;
    r = a[6];
    i = 6;
    k = 0;
    while (i >= 0 && a[i] == r) begin
      k++;
      i--;
    end
    k = r ? k - 1 : -k;
    i--;
    fb = (i >= 0) ? i + 1 : 0;
    m = longint'((1 << fb) | (int'(a) & ((1 << fb) - 1)));
    v = m <<< (24 + k - fb);
    return p[7] ? -v : v;
  endfunction

  function automatic logic [7:0] q2p(input longint q);
    logic [7:0] best = 8'h00;
    longint     bd = 64'h7fff_ffff_ffff_ffff;
    longint     d;
    for (int c = 0; c < 256; c++) begin
      if (c != 128) begin
        d = p2q(8'(c)) - q;
        if (d < 0) d = -d;
        if (d < bd) begin
          bd = d;
          best = 8'(c);
        end
      end
    end
    return best;
  endfunction

  // MAC model: output is only meaningful while the result request is high.
  longint quire;
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) quire <= 0;
    else if (mac_purge) quire <= 0;
    else if (mac_en) quire <= quire + ((p2q(mac_in1) * p2q(mac_in2)) >>> 24);
  end

  always_comb begin
    mac_out = 8'hA5;
    if (mac_req) mac_out = q2p(quire);
  end

  always @(negedge CLK) begin
    if (RESET) begin
      if (mac_purge) n_purge++;
      if (mac_en) n_en++;
      if (mac_req) n_req++;
      if (int'(mac_purge) + int'(mac_en) + int'(mac_req) > 1) n_ovl++;
      if (res_valid && res_ready) begin
        check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) check_eq("res_data", res_data, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc_rel++;
    if (mac_req) req_cyc = cyc_rel;
  endtask

  task automatic run_vec(input string tag, input int n, input int stall, input int hold,
                         input logic [7:0] exp_res, input int exp_lat);
    int   waited;
    logic rdy;
    n_purge = 0;
    n_en    = 0;
    n_req   = 0;
    n_ovl   = 0;
    cyc_rel = 0;
    req_cyc = -1;
    start   = 1'b1;
    len     = 8'(n);
    sb.push_back(exp_res);
    tick();
    start = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_a     = a_tab[k];
      in_b     = b_tab[k];
      in_valid = 1'b1;
      waited   = 0;
      do begin
        rdy = in_ready;
        tick();
        waited++;
      end while (!rdy && waited < 20);
      if (!rdy) check_eq({tag, " accept"}, 32'(rdy), 1);
      in_valid = 1'b0;
      if (k < n - 1) begin
        for (int s = 0; s < stall; s++) begin
          tick();
          if (s > 0) check_eq({tag, " stall_en"}, 32'(mac_en), 0);
        end
      end
    end
    waited = 0;
    while (!res_valid && waited < 50) begin
      tick();
      waited++;
    end
    check_eq({tag, " latency"}, 32'(cyc_rel), 32'(exp_lat));
    check_eq({tag, " req_cycle"}, 32'(req_cyc), 32'(exp_lat - 1));
    for (int h = 0; h < hold; h++) begin
      start = ~start;
      tick();
      check_eq({tag, " hold_data"}, res_data, exp_res);
      check_eq({tag, " hold_valid"}, 32'(res_valid), 1);
    end
    start     = 1'b0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq({tag, " idle_busy"}, 32'(busy), 0);
    check_eq({tag, " idle_valid"}, 32'(res_valid), 0);
    check_eq({tag, " purges"}, 32'(n_purge), 1);
    check_eq({tag, " enables"}, 32'(n_en), 32'(n));
    check_eq({tag, " requests"}, 32'(n_req), 1);
    check_eq({tag, " overlap"}, 32'(n_ovl), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int   acc, waited;
    logic rdy;
    // Reset values
    #12;
    check_eq("reset_outs", {mac_in1, mac_in2, mac_en, mac_purge, mac_req, res_valid,
                            res_data, in_ready, busy}, 0);
    RESET = 1'b1;
    cyc_rel = 0;
    tick();
    tick();
    check_eq("post_reset_busy", {busy, in_ready, mac_purge}, 0);

    // 1*1 + 2*0.5 = 2.0
    a_tab[0] = 8'h40; b_tab[0] = 8'h40;
    a_tab[1] = 8'h60; b_tab[1] = 8'h20;
    run_vec("two_elem", 2, 0, 0, 8'h60, 6);

    // 1+1+1 = 3.0, which encodes as 0x68 in posit8 with es=0
    for (int k = 0; k < 3; k++) begin
      a_tab[k] = 8'h40;
      b_tab[k] = 8'h40;
    end
    run_vec("stalled", 3, 2, 0, 8'h68, 11);

    run_vec("zero_len", 0, 0, 0, 8'h00, 3);

    a_tab[0] = 8'h40; b_tab[0] = 8'hC0;
    run_vec("backpressure", 1, 0, 5, 8'hC0, 5);

    // Abort a 4-beat vector after two beats
    cyc_rel = 0;
    start   = 1'b1;
    len     = 8'd4;
    tick();
    start    = 1'b0;
    in_a     = 8'h70;
    in_b     = 8'h70;
    in_valid = 1'b1;
    acc      = 0;
    waited   = 0;
    while (acc < 2 && waited < 20) begin
      rdy = in_ready;
      tick();
      waited++;
      if (rdy) acc++;
    end
    check_eq("abort_beats", 32'(acc), 2);
    in_valid = 1'b0;
    #2 RESET = 1'b0;
    #1;
    check_eq("reset_mid_outs", {mac_in1, mac_in2, mac_en, mac_purge, mac_req, res_valid,
                                res_data, in_ready, busy}, 0);
    RESET = 1'b1;
    tick();
    a_tab[0] = 8'h20; b_tab[0] = 8'h40;
    run_vec("after_abort", 1, 0, 0, 8'h20, 5);

    check_eq("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
